// File: rtl/prog_loader_rom.sv
// Program store with boot loader: streams an image in over valid/ready, then
// releases the core from reset and serves instruction bytes by address.
module prog_loader_rom #(
  parameter int         DEPTH     = 256,
  parameter logic [7:0] FILL_WORD = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] Address,
  output logic [7:0] Data,
  input  logic       ld_start,
  input  logic       ld_valid,
  input  logic [7:0] ld_data,
  input  logic       ld_last,
  output logic       ld_ready,
  output logic       cpu_rst,
  output logic       loading,
  output logic       done,
  output logic [7:0] ld_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN
  } state_t;

  state_t     state_q, state_d;
  logic [8:0] wptr_q, wptr_d;
  logic [7:0] ld_count_q, ld_count_d;
  logic       cpu_rst_q, cpu_rst_d;
  logic [8:0] wptr_inc;
  logic       accept;
  logic       addr_ok;

  logic [7:0] mem [DEPTH];

  assign wptr_inc = wptr_q + 9'd1;
  assign accept   = (state_q == LOAD) && ld_valid;
  assign addr_ok  = ({1'b0, Address} < 9'(DEPTH));

  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    ld_count_d = ld_count_q;
    case (state_q)
      IDLE: begin
        if (ld_start) begin
          state_d    = LOAD;
          wptr_d     = 9'd0;
          ld_count_d = 8'd0;
        end
      end
      LOAD: begin
        if (ld_valid) begin
          wptr_d = wptr_inc;
          // A full 256-entry image cannot be counted in 8 bits; pin it at 255.
          ld_count_d = wptr_inc[8] ? 8'hFF : wptr_inc[7:0];
          if (ld_last || (wptr_q == 9'(DEPTH - 1))) begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (ld_start) begin
          state_d    = LOAD;
          wptr_d     = 9'd0;
          ld_count_d = 8'd0;
        end
      end
      default: state_d = IDLE;
    endcase
    // Registered from next state so the core sees reset drop exactly on RUN entry.
    cpu_rst_d = (state_d != RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wptr_q     <= 9'd0;
      ld_count_q <= 8'd0;
      cpu_rst_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      ld_count_q <= ld_count_d;
      cpu_rst_q  <= cpu_rst_d;
    end
  end

  // Storage is deliberately outside the reset domain so images survive a reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wptr_q[AW-1:0]] <= ld_data;
    end
  end

  assign Data     = ((state_q == RUN) && addr_ok) ? mem[Address[AW-1:0]] : FILL_WORD;
  assign ld_ready = (state_q == LOAD);
  assign loading  = (state_q == LOAD);
  assign done     = (state_q == RUN);
  assign cpu_rst  = cpu_rst_q;
  assign ld_count = ld_count_q;

endmodule

// File: tb/tb_prog_loader_rom.sv
// Randomized and directed checking of prog_loader_rom against a byte-level
// model of the loader image, run with a 16-entry store.
module tb_prog_loader_rom;

  localparam int         DEPTH = 16;
  localparam logic [7:0] FILL  = 8'h00;
  localparam int         P_IDLE = 0;
  localparam int         P_LOAD = 1;
  localparam int         P_RUN  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] Address = 8'h00;
  logic [7:0] Data;
  logic       ld_start = 1'b0;
  logic       ld_valid = 1'b0;
  logic [7:0] ld_data = 8'h00;
  logic       ld_last = 1'b0;
  logic       ld_ready;
  logic       cpu_rst;
  logic       loading;
  logic       done;
  logic [7:0] ld_count;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  prog_loader_rom #(.DEPTH(DEPTH), .FILL_WORD(FILL)) dut (
    .clk      (clk),
    .rst      (rst),
    .Address  (Address),
    .Data     (Data),
    .ld_start (ld_start),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .ld_last  (ld_last),
    .ld_ready (ld_ready),
    .cpu_rst  (cpu_rst),
    .loading  (loading),
    .done     (done),
    .ld_count (ld_count)
  );

  // Reference: which phase the loader is in, how many bytes this image has,
  // and the image bytes themselves (with a flag for locations ever written).
  int         m_phase = P_IDLE;
  int         m_bytes = 0;
  bit         m_cpu_rst = 1'b1;
  logic [7:0] m_mem [DEPTH];
  bit         m_known [DEPTH];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase   = P_IDLE;
      m_bytes   = 0;
      m_cpu_rst = 1'b1;
    end else begin
      if (m_phase == P_LOAD) begin
        if (ld_valid) begin
          m_mem[m_bytes]   = ld_data;
          m_known[m_bytes] = 1'b1;
          m_bytes          = m_bytes + 1;
          if (ld_last || m_bytes == DEPTH) m_phase = P_RUN;
        end
      end else if (ld_start) begin
        m_phase = P_LOAD;
        m_bytes = 0;
      end
      m_cpu_rst = (m_phase != P_RUN);
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Every-cycle comparison of all outputs against the reference.
  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("cyc_cpu_rst", int'(cpu_rst), int'(m_cpu_rst));
      checkOutput("cyc_ld_ready", int'(ld_ready), int'(m_phase == P_LOAD));
      checkOutput("cyc_loading", int'(loading), int'(m_phase == P_LOAD));
      checkOutput("cyc_done", int'(done), int'(m_phase == P_RUN));
      checkOutput("cyc_ld_count", int'(ld_count), m_bytes);
      if (m_phase == P_RUN && int'(Address) < DEPTH) begin
        if (m_known[Address[3:0]]) checkOutput("cyc_data", int'(Data), int'(m_mem[Address[3:0]]));
      end else begin
        checkOutput("cyc_data_fill", int'(Data), int'(FILL));
      end
    end
  end

  task automatic applyStimulus(input bit start, input bit valid, input logic [7:0] data, input bit last);
    ld_start = start;
    ld_valid = valid;
    ld_data  = data;
    ld_last  = last;
    @(posedge clk);
    #1;
    ld_start = 1'b0;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic readAt(input logic [7:0] addr, input logic [7:0] expected, input string name);
    Address = addr;
    #1;
    checkOutput(name, int'(Data), int'(expected));
  endtask

  initial begin
    int seen;

    Address = 8'h05;
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    checkOutput("rst_cpu_rst", int'(cpu_rst), 1);
    checkOutput("rst_ld_ready", int'(ld_ready), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_loading", int'(loading), 0);
    checkOutput("rst_ld_count", int'(ld_count), 0);
    checkOutput("rst_data", int'(Data), 8'h00);
    rst = 1'b0;
    repeat (2) applyStimulus(0, 0, 8'h00, 0);

    // Basic back-to-back load of three bytes.
    applyStimulus(1, 0, 8'h00, 0);
    applyStimulus(0, 1, 8'h1A, 0);
    applyStimulus(0, 1, 8'h2B, 0);
    applyStimulus(0, 1, 8'h3C, 1);
    checkOutput("basic_count", int'(ld_count), 3);
    checkOutput("basic_done", int'(done), 1);
    checkOutput("basic_cpu_rst", int'(cpu_rst), 0);
    readAt(8'h00, 8'h1A, "basic_a0");
    readAt(8'h01, 8'h2B, "basic_a1");
    readAt(8'h02, 8'h3C, "basic_a2");

    // Gapped load; a stray ld_start inside the gap must not restart the image.
    applyStimulus(1, 0, 8'h00, 0);
    applyStimulus(0, 1, 8'h1A, 0);
    applyStimulus(0, 0, 8'h00, 0);
    applyStimulus(1, 0, 8'h00, 0);
    checkOutput("gap_count_hold", int'(ld_count), 1);
    applyStimulus(0, 1, 8'h2B, 0);
    repeat (2) applyStimulus(0, 0, 8'h00, 0);
    applyStimulus(0, 1, 8'h3C, 1);
    checkOutput("gap_count", int'(ld_count), 3);
    readAt(8'h00, 8'h1A, "gap_a0");
    readAt(8'h01, 8'h2B, "gap_a1");
    readAt(8'h02, 8'h3C, "gap_a2");

    // Overflow: 20 bytes offered, only DEPTH of them may be taken.
    applyStimulus(1, 0, 8'h00, 0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      ld_valid = 1'b1;
      ld_data  = 8'(i);
      ld_last  = 1'b0;
      if (ld_ready) seen++;
      @(posedge clk);
      #1;
    end
    ld_valid = 1'b0;
    checkOutput("ovf_accepted", seen, 16);
    checkOutput("ovf_count", int'(ld_count), 16);
    checkOutput("ovf_done", int'(done), 1);
    readAt(8'h10, FILL, "ovf_a10");
    readAt(8'h0F, 8'h0F, "ovf_a0f");
    readAt(8'h07, 8'h07, "ovf_a07");

    // Reset in the middle of a four-byte load.
    applyStimulus(1, 0, 8'h00, 0);
    applyStimulus(0, 1, 8'h55, 0);
    applyStimulus(0, 1, 8'h66, 0);
    ld_valid = 1'b1;
    ld_data  = 8'h99;
    rst      = 1'b1;
    #2;
    checkOutput("mid_rst_cpu_rst", int'(cpu_rst), 1);
    checkOutput("mid_rst_count", int'(ld_count), 0);
    checkOutput("mid_rst_ready", int'(ld_ready), 0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    ld_valid = 1'b0;
    applyStimulus(0, 1, 8'hAA, 0);
    checkOutput("idle_no_load", int'(loading), 0);
    applyStimulus(1, 1, 8'hBB, 0);
    applyStimulus(0, 1, 8'h77, 1);
    checkOutput("after_rst_count", int'(ld_count), 1);
    readAt(8'h00, 8'h77, "after_rst_a0");
    readAt(8'h01, 8'h66, "after_rst_a1");
    readAt(8'h02, 8'h02, "after_rst_a2");

    // Reload from RUN.
    Address = 8'h00;
    applyStimulus(1, 0, 8'h00, 0);
    checkOutput("reload_cpu_rst", int'(cpu_rst), 1);
    checkOutput("reload_done", int'(done), 0);
    checkOutput("reload_fill", int'(Data), int'(FILL));
    applyStimulus(0, 1, 8'hE0, 1);
    checkOutput("reload_done2", int'(done), 1);
    readAt(8'h00, 8'hE0, "reload_a0");
    readAt(8'h01, 8'h66, "reload_a1");
    readAt(8'h03, 8'h03, "reload_a3");

    // Random traffic, including stray ld_last, restarts and occasional resets.
    for (int n = 0; n < 1500; n++) begin
      Address = 8'($urandom_range(0, 31));
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
      end else begin
        applyStimulus($urandom_range(0, 99) < 4, $urandom_range(0, 99) < 60,
                      8'($urandom), $urandom_range(0, 99) < 10);
      end
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
